// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART definitions: frame geometry, receiver FSM state encoding and
// the 2-of-3 vote used to de-noise line samples.
package uart_rx_oversample_pkg;

  // Oversample ticks per bit; the bit counter runs 0..OSR-1.
  localparam int OSR         = 16;
  // Centre sample index; votes are taken at SAMPLE_MID-1, SAMPLE_MID and SAMPLE_MID+1.
  localparam int SAMPLE_MID  = 8;
  // Data bits per frame, LSB first on the line.
  localparam int DATA_BITS   = 8;
  // Flip-flops in each input synchroniser.
  localparam int SYNC_STAGES = 2;

  // Receiver states, 2-bit encoded so the encoding is the same in every UART block.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Majority of three samples: a single-sample spike can never flip the result.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_sync.sv
// Multi-flop synchroniser with a rising-edge detector on its output.
// Used for the baud square wave (edge output becomes the oversample tick) and
// for the serial line (level output only).
module uart_rx_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sys_clk_i,
  input  logic rst_n_baud,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the asynchronous input through the chain and remember the last synced level.
  // Resetting to the idle level keeps a released reset from looking like an edge.
  always_ff @(posedge sys_clk_i or negedge rst_n_baud) begin
    if (!rst_n_baud) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver running on the system clock. The 16x oversample square
// wave from the baud generator is synchronised and its rising edge used as a
// one-cycle tick; all framing work happens on tick cycles only. Each bit is
// decided by a 2-of-3 vote around the bit centre, and finished bytes are
// handed out through a valid/ready holding register with framing and overrun
// flags.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int OSR         = uart_rx_oversample_pkg::OSR,
  parameter int SAMPLE_MID  = uart_rx_oversample_pkg::SAMPLE_MID,
  parameter int DATA_BITS   = uart_rx_oversample_pkg::DATA_BITS,
  parameter int SYNC_STAGES = uart_rx_oversample_pkg::SYNC_STAGES
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_n_baud,
  input  logic                 baud_clk_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int OS_W  = $clog2(OSR);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]  SMP_LO   = OS_W'(SAMPLE_MID - 1);
  localparam logic [OS_W-1:0]  SMP_MID  = OS_W'(SAMPLE_MID);
  localparam logic [OS_W-1:0]  SMP_HI   = OS_W'(SAMPLE_MID + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic tick;
  logic rx_s;
  logic baud_level_unused;
  logic rx_rise_unused;

  uart_rx_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_baud_sync (
    .sys_clk_i  (sys_clk_i),
    .rst_n_baud (rst_n_baud),
    .d          (baud_clk_i),
    .level      (baud_level_unused),
    .rise       (tick)
  );

  // The line only needs its level; its edge output is deliberately left unused.
  uart_rx_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .sys_clk_i  (sys_clk_i),
    .rst_n_baud (rst_n_baud),
    .d          (rx_i),
    .level      (rx_s),
    .rise       (rx_rise_unused)
  );

  // ---------------------------------------------------------------------------
  // Framing state
  // ---------------------------------------------------------------------------
  rx_state_e            state;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [2:0]           smp;      // samples at SMP_LO, SMP_MID, SMP_HI
  logic [DATA_BITS-1:0] shift;

  // Start and data bits are decided at the end of the bit, when all three
  // samples are latched. The stop bit is decided on the tick that takes its
  // third sample, so that sample comes straight from the line.
  logic bit_vote;
  logic stop_vote;
  logic complete;

  assign bit_vote  = maj3(smp[0], smp[1], smp[2]);
  assign stop_vote = maj3(smp[0], smp[1], rx_s);
  assign complete  = tick && (state == ST_STOP) && (os_cnt == SMP_HI);

  // Receiver FSM: advances only on oversample ticks, busy_o registered alongside the state.
  // NOTE: every register in a clocked block is assigned with <= so all of them
  // see the pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge sys_clk_i or negedge rst_n_baud) begin
    if (!rst_n_baud) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      smp     <= '0;
      shift   <= '0;
      busy_o  <= 1'b0;
    end else if (tick) begin
      if (state != ST_IDLE) begin
        if (os_cnt == SMP_LO)  smp[0] <= rx_s;
        if (os_cnt == SMP_MID) smp[1] <= rx_s;
        if (os_cnt == SMP_HI)  smp[2] <= rx_s;
      end

      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state  <= ST_START;
            os_cnt <= '0;
            busy_o <= 1'b1;
          end
        end

        ST_START: begin
          if (os_cnt == OS_LAST) begin
            os_cnt <= '0;
            if (bit_vote) begin
              // Line was back high at the centre: a glitch, not a start bit.
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (os_cnt == OS_LAST) begin
            os_cnt <= '0;
            shift  <= {bit_vote, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (os_cnt == SMP_HI) begin
            // Leave half a bit early so the next start edge is caught on time.
            state  <= ST_IDLE;
            os_cnt <= '0;
            busy_o <= 1'b0;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------------

  // Load completed bytes when the holder is free (or being emptied this cycle),
  // otherwise keep the old byte and flag the loss; flags are single-cycle pulses.
  always_ff @(posedge sys_clk_i or negedge rst_n_baud) begin
    if (!rst_n_baud) begin
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= complete && !stop_vote;
      overrun_o   <= complete && rx_valid_o && !rx_ready_i;

      if (complete && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o  <= shift;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule
